// File: rtl/seg_scan_scheduler.sv
// Multiplexed 3-digit 7-segment scan scheduler: blank/show per digit slot, frame-atomic data commit.
// Optional build macro LEADING_ZERO_SUPPRESS_EN blanks leading zero digits 2 and 1.
module seg_scan_scheduler #(
  parameter int FREQUENCY    = 27_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 2700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [11:0] load_data,
  output logic        load_ready,
  output logic [2:0]  a,
  output logic [6:0]  seg
);

  localparam int SLOT_CYCLES = FREQUENCY / REFRESH_HZ;
  localparam int SHOW_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
  localparam int CW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_cfg_err
    $error("seg_scan_scheduler: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < SLOT_CYCLES");
  end

  typedef enum logic {BLANK, SHOW} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [11:0]   active_q, active_d;
  logic [11:0]   pending_q;
  logic          pfull_q;
  logic          ready_q;
  logic [2:0]    a_q;
  logic [6:0]    seg_q;

  logic          boundary, commit, accept, blank_digit;
  logic [3:0]    digit_d;
  logic [6:0]    seg_show_d;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    boundary = (state_q == BLANK) && (cnt_q == BLANK_LAST) && (idx_q == 2'd0);
    commit   = boundary && pfull_q;
    accept   = load_valid && ready_q;
    // Digit 0 of a fresh frame is decoded straight from the value being committed.
    active_d = commit ? pending_q : active_q;
    case (idx_q)
      2'd1:    digit_d = active_d[7:4];
      2'd2:    digit_d = active_d[11:8];
      default: digit_d = active_d[3:0];
    endcase
`ifdef LEADING_ZERO_SUPPRESS_EN
    blank_digit = ((idx_q == 2'd2) && (active_d[11:8] == 4'h0)) ||
                  ((idx_q == 2'd1) && (active_d[11:4] == 8'h00));
`else
    blank_digit = 1'b0;
`endif
    seg_show_d = blank_digit ? 7'h00 : hex7(digit_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      active_q  <= '0;
      pending_q <= '0;
      pfull_q   <= 1'b0;
      ready_q   <= 1'b0;
      a_q       <= 3'b000;
      seg_q     <= 7'h00;
    end else begin
      // Ready stays low through the commit cycle and rises on the one after.
      ready_q  <= !pfull_q && !accept;
      active_q <= active_d;
      if (accept) begin
        pending_q <= load_data;
        pfull_q   <= 1'b1;
      end else if (commit) begin
        pfull_q   <= 1'b0;
      end
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            a_q     <= 3'b001 << idx_q;
            seg_q   <= seg_show_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == SHOW_LAST) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            a_q     <= 3'b000;
            seg_q   <= 7'h00;
            idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign a          = a_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: 10-cycle slots (2 blank + 8 show), 30-cycle frames, frame-level model.
module tb_seg_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [11:0] load_data = '0;
  logic        load_ready;
  logic [2:0]  a;
  logic [6:0]  seg;

  int checks = 0;
  int failures = 0;

  // Model state: n = rising edges since reset release; frame position is n mod 30.
  int          n = 0;
  logic [11:0] m_act = '0;
  logic [11:0] m_pend = '0;
  bit          m_pfull = 0;
  bit          m_rdy = 0;
  bit          last_acc = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_scheduler #(.FREQUENCY(1000), .REFRESH_HZ(100), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .a(a), .seg(seg)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] exp_glyph(input int k, input logic [11:0] v);
    logic [3:0] dg;
    dg = 4'((v >> (4 * k)) & 12'hF);
`ifdef LEADING_ZERO_SUPPRESS_EN
    if (k == 2 && v[11:8] == 4'h0) return 7'h00;
    if (k == 1 && v[11:4] == 8'h00) return 7'h00;
`endif
    return glyph[dg];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h n=%0d", tag, got, exp, n);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [11:0] d);
    bit commit;
    int p;
    rst = r; load_valid = v; load_data = d;
    @(posedge clk);
    last_acc = 0;
    if (r) begin
      n = 0; m_act = '0; m_pfull = 0; m_rdy = 0;
    end else begin
      n++;
      commit = (n % 30 == 2) && m_pfull;
      if (v && m_rdy) begin
        m_pend = d; m_pfull = 1; last_acc = 1;
      end
      if (commit) begin
        m_act = m_pend; m_pfull = 0;
      end
      m_rdy = !m_pfull && !commit;
    end
    @(negedge clk);
    p = n % 30;
    if (p % 10 >= 2) begin
      chk("a", 16'(a), 16'(3'b001 << (p / 10)));
      chk("seg", 16'(seg), 16'(exp_glyph(p / 10, m_act)));
    end else begin
      chk("a", 16'(a), 16'h0);
      chk("seg", 16'(seg), 16'h0);
    end
    chk("load_ready", 16'(load_ready), 16'(m_rdy));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, '0);
  endtask

  // Advance until the frame position equals p (bounded by one frame).
  task automatic goto_pos(input int p);
    for (int i = 0; i < 31 && (n % 30) != p; i++) step(0, 0, '0);
  endtask

  initial begin
    int guard;
    logic [11:0] rd;
    step(1, 0, '0); step(1, 1, 12'hFFF); step(1, 0, '0);

    // Idle scan after reset: 2 blank, then 0 on every digit.
    idle(60);

    // Mid-frame load.
    goto_pos(15);
    step(0, 1, 12'h123);
    idle(50);

    // Back-to-back loads: second stalls until the first is committed.
    goto_pos(5);
    step(0, 1, 12'h456);
    guard = 0;
    do begin
      step(0, 1, 12'h789);
      guard++;
    end while (!last_acc && guard < 100);
    chk("second_load_accepted", 16'(last_acc), 16'h1);
    idle(70);

    // Load on the boundary edge itself.
    goto_pos(1);
    step(0, 1, 12'hABC);
    chk("boundary_load_accepted", 16'(last_acc), 16'h1);
    idle(65);

    // Reset during digit1 show with pending full.
    goto_pos(3);
    step(0, 1, 12'hDEF);
    idle(32);
    step(0, 1, 12'h321);
    goto_pos(14);
    chk("pending_full_before_rst", 16'(m_pfull), 16'h1);
    step(1, 0, '0); step(1, 1, 12'h555);
    idle(70);

    // Leading zero case.
    goto_pos(20);
    step(0, 1, 12'h007);
    idle(70);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rd = 12'($urandom);
      step(($urandom % 400) == 0, ($urandom % 6) == 0, rd);
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
